// File: rtl/acc_pkg.sv
// Shared defaults and types for the accumulate15 group-sum block.
// Optional feature macro: ACC_SATURATE_EN (saturating accumulation).
package acc_pkg;

    localparam int ACC_DATA_W    = 32;
    localparam int ACC_N_SAMPLES = 15;
    localparam int ACC_CNT_W     = $clog2(ACC_N_SAMPLES);

    typedef logic [ACC_DATA_W-1:0] acc_data_t;
    typedef logic [ACC_CNT_W-1:0]  acc_cnt_t;

endpackage

// File: rtl/acc_sample_counter.sv
// Counts valid samples within a group and flags the last one.
// Optional feature macro: ACC_SATURATE_EN (not used in this file).
module acc_sample_counter
    import acc_pkg::*;
#(
    parameter int N_SAMPLES = ACC_N_SAMPLES,
    parameter int CNT_W     = $clog2(N_SAMPLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    output logic             last_sample,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);

    // The current valid sample closes the group.
    always_comb begin
        last_sample = valid && (cnt == CNT_LAST);
    end

    // Advance on each valid sample; wrap to zero after the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (valid) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/accumulate15.sv
// Sums mult_data over groups of N_SAMPLES valid samples and emits one
// registered result with a one-cycle valid_out pulse per group.
// Optional feature macro: ACC_SATURATE_EN -- clamp the running sum at all-ones
// instead of wrapping modulo 2^DATA_W.
//
// Stream semantics: a sample transfers on every rising edge where mult_valid
// is 1 (there is no ready; the block always accepts). valid_out is a one-cycle
// pulse the downstream must take unconditionally; data_out holds the last
// group sum between pulses.
module accumulate15
    import acc_pkg::*;
#(
    parameter int DATA_W    = ACC_DATA_W,
    parameter int N_SAMPLES = ACC_N_SAMPLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mult_valid,
    input  logic [DATA_W-1:0] mult_data,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [$clog2(N_SAMPLES)-1:0] cnt
);

    localparam int CNT_W = $clog2(N_SAMPLES);

    logic              last_sample;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] sum;

    acc_sample_counter #(
        .N_SAMPLES (N_SAMPLES),
        .CNT_W     (CNT_W)
    ) u_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid       (mult_valid),
        .last_sample (last_sample),
        .cnt         (cnt)
    );

`ifdef ACC_SATURATE_EN
    logic [DATA_W:0] sum_wide;

    // Widened add; a carry-out pins the sum at all-ones. Once pinned, any
    // further add either carries again or adds zero, so it stays clamped.
    always_comb begin
        sum_wide = {1'b0, acc} + {1'b0, mult_data};
        sum      = sum_wide[DATA_W] ? {DATA_W{1'b1}} : sum_wide[DATA_W-1:0];
    end
`else
    // Plain modulo-2^DATA_W add.
    always_comb begin
        sum = acc + mult_data;
    end
`endif

    // Running sum: restarts at zero after the last sample of each group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (mult_valid) begin
            if (last_sample) begin
                acc <= '0;
            end else begin
                acc <= sum;
            end
        end
    end

    // Publish the completed group sum with a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= last_sample;
            if (last_sample) begin
                data_out <= sum;
            end
        end
    end

endmodule

// File: tb/tb_accumulate15.sv
// Self-checking bench for accumulate15: directed scenarios followed by random
// traffic, compared against a group-sum reference model.
module tb_accumulate15;
    import acc_pkg::*;

    localparam int N = ACC_N_SAMPLES;
    localparam longint unsigned MAXV = 64'hFFFF_FFFF;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    logic      mult_valid = 1'b0;
    acc_data_t mult_data = '0;
    acc_data_t data_out;
    logic      valid_out;
    acc_cnt_t  cnt;

    accumulate15 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mult_valid (mult_valid),
        .mult_data  (mult_data),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .cnt        (cnt)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model: list of samples in the open group, last published sum.
    longint unsigned grp[$];
    acc_data_t       m_data;
    logic            m_valid;
    acc_data_t       exp_q[$];

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    function automatic acc_data_t group_result();
        longint unsigned total = 0;
        foreach (grp[i]) total += grp[i];
`ifdef ACC_SATURATE_EN
        return (total > MAXV) ? acc_data_t'(MAXV) : acc_data_t'(total);
`else
        return acc_data_t'(total % (MAXV + 1));
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        grp.delete();
        exp_q.delete();
        m_data  = '0;
        m_valid = 1'b0;
    endtask

    task automatic model_edge(input logic v, input acc_data_t d);
        m_valid = 1'b0;
        if (v) begin
            grp.push_back(longint'(d));
            if (grp.size() == N) begin
                m_data  = group_result();
                m_valid = 1'b1;
                exp_q.push_back(m_data);
                grp.delete();
            end
        end
    endtask

    task automatic check_outputs();
        check("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
        check("data_out", data_out, m_data);
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_pulse", 32'd1, 32'd0);
            else check("group_sum", data_out, exp_q.pop_front());
        end
    endtask

    // Driver: present one cycle of input, then check after the edge.
    task automatic step(input logic v, input acc_data_t d);
        @(negedge clk);
        mult_valid = v;
        mult_data  = d;
        @(posedge clk);
        #1;
        model_edge(v, d);
        check_outputs();
    endtask

    task automatic idle_x();
        @(negedge clk);
        mult_valid = 1'b0;
        mult_data  = 'x;
        @(posedge clk);
        #1;
        model_edge(1'b0, '0);
        check_outputs();
    endtask

    // Asynchronous reset pulse, asserted away from any clock edge.
    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check("rst_valid_out", {31'b0, valid_out}, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        @(negedge clk);
        mult_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        model_clear();
        pulse_reset();

        // Idle after reset: nothing published.
        for (int i = 0; i < 5; i++) step(1'b0, acc_data_t'($urandom));
        check("idle_data_zero", data_out, 32'd0);

        // 10 ones, idle gap with X data, then 3s: pulse after the 5th three.
        for (int i = 0; i < 10; i++) step(1'b1, 32'd1);
        for (int i = 0; i < 6; i++) idle_x();
        for (int i = 0; i < 4; i++) step(1'b1, 32'd3);
        check("gap_no_early_pulse", {31'b0, valid_out}, 32'd0);
        step(1'b1, 32'd3);
        check("gap_pulse", {31'b0, valid_out}, 32'd1);
        check("gap_sum_25", data_out, 32'd25);
        step(1'b0, 32'd0);
        check("pulse_one_cycle", {31'b0, valid_out}, 32'd0);
        check("data_held", data_out, 32'd25);

        // 30 back-to-back twos: two pulses, 30 each.
        for (int i = 1; i <= 30; i++) begin
            step(1'b1, 32'd2);
            if (i == 15 || i == 30) begin
                check("b2b_pulse", {31'b0, valid_out}, 32'd1);
                check("b2b_sum_30", data_out, 32'd30);
            end
        end
        step(1'b0, 32'd0);

        // Reset mid-group discards the partial sum.
        for (int i = 0; i < 7; i++) step(1'b1, 32'd9);
        pulse_reset();
        for (int i = 0; i < 15; i++) step(1'b1, 32'd4);
        check("post_reset_sum_60", data_out, 32'd60);
        check("post_reset_pulse", {31'b0, valid_out}, 32'd1);

        // Overflow boundary.
        for (int i = 0; i < 15; i++) step(1'b1, 32'hFFFF_FFFF);
`ifdef ACC_SATURATE_EN
        check("overflow_sum", data_out, 32'hFFFF_FFFF);
`else
        check("overflow_sum", data_out, 32'hFFFF_FFF1);
`endif
        step(1'b0, 32'd0);

        // Random traffic with mixed magnitudes and occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else if ($urandom_range(0, 3) == 0) begin
                idle_x();
            end else if ($urandom_range(0, 1) == 0) begin
                step(1'b1, acc_data_t'($urandom));
            end else begin
                step(1'b1, acc_data_t'($urandom_range(0, 1000)));
            end
        end
        step(1'b0, 32'd0);
        check("no_pending_sums", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
